pacman_mover: RTL
=================

PACMAN_MOVER -- requirements
Module: pacman_mover

Interface
REQ-001 Parameters SHALL be: ROW, default 36, tile rows with x range 0..ROW-1; COL, default 28, tile columns with y range 0..COL-1; START_X, default 26, reset x; START_Y, default 13, reset y; ACK_TIMEOUT, default 15, maximum wait cycles for a tile-lookup acknowledge.
REQ-002 i_clk  in  1  the single clock, with all logic rising-edge triggered.
REQ-003 i_rst_n  in  1  the reset, which is synchronous and active-low.
REQ-004 i_step  in  1  one-cycle move tick.
REQ-005 i_dir_valid  in  1  player direction strobe.
REQ-006 i_dir  in  2  requested direction: 0 = x-1, 1 = x+1, 2 = y-1, 3 = y+1.
REQ-007 o_tile_req  out  1  maze lookup request.
REQ-008 o_tile_x / o_tile_y  out  6 each  tile being queried.
REQ-009 i_tile_ack  in  1  lookup response valid.
REQ-010 i_tile_wall  in  1  tile is wall, sampled only with i_tile_ack.
REQ-011 i_ghost_x / i_ghost_y  in  6 each  ghost tile position.
REQ-012 o_pac_x / o_pac_y  out  6 each  Pac-Man tile position, the producer side for the ghost chaser.
REQ-013 o_busy  out  1  a move is in progress (FSM not IDLE).
REQ-014 o_caught  out  1  sticky ghost-collision flag.
REQ-015 o_timeout  out  1  one-cycle pulse when a lookup is aborted.

Function
REQ-016 The block SHALL keep a pending-direction register: any i_dir_valid cycle loads i_dir and sets pend_v, in any state; the latest strobe wins.
REQ-017 The block SHALL keep a current direction: cur_dir with cur_v, which is 0 after reset.
REQ-018 The FSM SHALL have the states IDLE, REQ_NEXT, REQ_CUR and CAUGHT.
REQ-019 IDLE + i_step: if pend_v is set, go to REQ_NEXT; else if cur_v is set, go to REQ_CUR; else stay in IDLE.
REQ-020 i_step outside IDLE SHALL be ignored (no queuing).
REQ-021 Target tile: x +/-1 per direction; y +/-1 with wrap-around (y=0 going -1 gives COL-1; y=COL-1 going +1 gives 0), which is the tunnel.
REQ-022 Target x outside 0..ROW-1 SHALL be treated as a wall immediately, with no request issued, resolved in the entry cycle.
REQ-023 On entry to REQ_NEXT or REQ_CUR the block SHALL assert o_tile_req with the target on o_tile_x/y, holding all three stable until the ack cycle.
REQ-024 o_tile_req SHALL drop in the cycle after i_tile_ack.
REQ-025 Ack with wall=0 SHALL load the target into o_pac_x/y on the next edge, return to IDLE, and, from REQ_NEXT only, set cur_dir to the pending direction, set cur_v, and clear pend_v.
REQ-026 Ack with wall=1 in REQ_NEXT SHALL keep pend_v and go to REQ_CUR if cur_v is set, else go to IDLE.
REQ-027 Ack with wall=1 in REQ_CUR SHALL clear cur_v (Pac-Man stops) and go to IDLE.
REQ-028 Wait counter: 4 bits, cleared on state entry; if it reaches ACK_TIMEOUT with no ack, the block SHALL drop o_tile_req, pulse o_timeout for 1 cycle, go to IDLE, leave the position unchanged, and keep pend_v and cur_v.
REQ-029 Latency SHALL be: step to o_tile_req is 1 cycle; ack to position update is 1 cycle; worst-case move is 2 lookups.
REQ-030 Collision: when o_pac_x/y equals i_ghost_x/y in any state other than CAUGHT, the block SHALL set o_caught on the next edge and enter CAUGHT, aborting any request (o_tile_req low).
REQ-031 CAUGHT SHALL be terminal until reset: the position is frozen and i_step, i_dir_valid and i_tile_ack are ignored.
REQ-032 An i_dir_valid in the same cycle as the ack that commits a pending move SHALL take priority over the clear: the new direction is loaded and pend_v stays 1.

Reset
REQ-033 On a rising edge with i_rst_n=0 the block SHALL set: o_pac_x=START_X, o_pac_y=START_Y, FSM=IDLE, o_tile_req=0, o_tile_x/y=0, o_busy=0, o_caught=0, o_timeout=0, pend_v=0, cur_v=0, counter=0.
REQ-034 Reset asserted mid-lookup SHALL abandon the request; a late i_tile_ack after reset SHALL be ignored in IDLE.

Verification
REQ-035 Reset, then dir=1 strobe, then step -> o_tile_req with tile (27,13) one cycle later; ack wall=0 -> o_pac=(27,13) and cur_v=1.
REQ-036 cur_dir=1 at (27,13), pending dir=2, step, wall on (27,12) -> second request for (28,13); ack wall=0 -> o_pac=(28,13), pend_v still 1.
REQ-037 At y=0 with dir=2, step -> request for (x,27); ack wall=0 -> o_pac_y=27 (tunnel wrap); at x=35 with dir=1 -> no o_tile_req and cur_v cleared.
REQ-038 Request with no ack for 15 cycles -> o_timeout pulses once, o_tile_req=0, position unchanged; a later stray ack causes no change.
REQ-039 Ghost set to o_pac during REQ_CUR -> o_caught=1 the next cycle, o_tile_req=0; further steps and acks leave the position frozen until i_rst_n=0.

Source files
------------

// File: rtl/pacman_mover.sv
// -----------------------------------------------------------------------------
// pacman_mover
//
// Moves Pac-Man one tile per accepted step tick. Each move asks an external
// maze lookup whether the target tile is a wall. The block first tries the
// player's pending direction. If that tile is a wall, it falls back to the
// current direction of travel. The y axis wraps around (the tunnel). An x
// target outside the maze counts as a wall without issuing a lookup. Touching
// the ghost latches a terminal CAUGHT state, which only reset clears.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | waiting for a step tick
// REQ_NEXT | looking up the tile in the pending (player-requested) direction
// REQ_CUR  | looking up the tile in the current direction of travel
// CAUGHT   | ghost collision seen; everything frozen until reset
//
// Ports
//   i_clk, i_rst_n           clock, synchronous active-low reset
//   i_step                   one-cycle move tick (ignored unless IDLE)
//   i_dir_valid, i_dir       direction strobe: 0 x-1, 1 x+1, 2 y-1, 3 y+1
//   o_tile_req, o_tile_x/y   maze lookup request and the tile being queried
//   i_tile_ack, i_tile_wall  lookup response; wall sampled only with ack
//   i_ghost_x/y              ghost tile position
//   o_pac_x/y                Pac-Man tile position
//   o_busy                   FSM not IDLE
//   o_caught                 sticky ghost-collision flag
//   o_timeout                one-cycle pulse when a lookup is abandoned
// -----------------------------------------------------------------------------
module pacman_mover #(
  parameter int ROW         = 36,
  parameter int COL         = 28,
  parameter int START_X     = 26,
  parameter int START_Y     = 13,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_step,
  input  logic       i_dir_valid,
  input  logic [1:0] i_dir,
  output logic       o_tile_req,
  output logic [5:0] o_tile_x,
  output logic [5:0] o_tile_y,
  input  logic       i_tile_ack,
  input  logic       i_tile_wall,
  input  logic [5:0] i_ghost_x,
  input  logic [5:0] i_ghost_y,
  output logic [5:0] o_pac_x,
  output logic [5:0] o_pac_y,
  output logic       o_busy,
  output logic       o_caught,
  output logic       o_timeout
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_REQ_NEXT = 2'd1,
    S_REQ_CUR  = 2'd2,
    S_CAUGHT   = 2'd3
  } state_e;

  typedef struct packed {
    logic       oob;
    logic [5:0] x;
    logic [5:0] y;
  } tgt_t;

  localparam logic [5:0] X_MAX   = 6'(ROW - 1);
  localparam logic [5:0] Y_MAX   = 6'(COL - 1);
  localparam logic [5:0] X_RST   = 6'(START_X);
  localparam logic [5:0] Y_RST   = 6'(START_Y);
  // Last wait cycle: with no ack here, the lookup is abandoned on this edge.
  localparam logic [3:0] TO_LAST = 4'(ACK_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [1:0] pend_dir_q, pend_dir_d;
  logic       pend_v_q, pend_v_d;
  logic [1:0] cur_dir_q, cur_dir_d;
  logic       cur_v_q, cur_v_d;
  logic       req_q, req_d;
  logic [5:0] tile_x_q, tile_x_d;
  logic [5:0] tile_y_q, tile_y_d;
  logic       oob_q, oob_d;
  logic [3:0] cnt_q, cnt_d;
  logic [5:0] pac_x_q, pac_x_d;
  logic [5:0] pac_y_q, pac_y_d;
  logic       caught_q, caught_d;
  logic       timeout_q, timeout_d;

  tgt_t pend_tgt;
  tgt_t cur_tgt;
  logic collision;

  // One tile away in direction dir. x is bounded (oob flags leaving the
  // maze); y wraps through the tunnel.
  function automatic tgt_t next_tile(input logic [1:0] dir,
                                     input logic [5:0] x,
                                     input logic [5:0] y);
    tgt_t t;
    t.oob = 1'b0;
    t.x   = x;
    t.y   = y;
    case (dir)
      2'd0: begin
        t.oob = (x == 6'd0);
        t.x   = x - 6'd1;
      end
      2'd1: begin
        t.oob = (x >= X_MAX);
        t.x   = x + 6'd1;
      end
      2'd2: t.y = (y == 6'd0) ? Y_MAX : y - 6'd1;
      2'd3: t.y = (y >= Y_MAX) ? 6'd0 : y + 6'd1;
      default: t.oob = 1'b1;
    endcase
    return t;
  endfunction

  assign pend_tgt  = next_tile(pend_dir_q, pac_x_q, pac_y_q);
  assign cur_tgt   = next_tile(cur_dir_q, pac_x_q, pac_y_q);
  assign collision = (pac_x_q == i_ghost_x) && (pac_y_q == i_ghost_y);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      pend_dir_q <= 2'd0;
      pend_v_q   <= 1'b0;
      cur_dir_q  <= 2'd0;
      cur_v_q    <= 1'b0;
      req_q      <= 1'b0;
      tile_x_q   <= 6'd0;
      tile_y_q   <= 6'd0;
      oob_q      <= 1'b0;
      cnt_q      <= 4'd0;
      pac_x_q    <= X_RST;
      pac_y_q    <= Y_RST;
      caught_q   <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_dir_q <= pend_dir_d;
      pend_v_q   <= pend_v_d;
      cur_dir_q  <= cur_dir_d;
      cur_v_q    <= cur_v_d;
      req_q      <= req_d;
      tile_x_q   <= tile_x_d;
      tile_y_q   <= tile_y_d;
      oob_q      <= oob_d;
      cnt_q      <= cnt_d;
      pac_x_q    <= pac_x_d;
      pac_y_q    <= pac_y_d;
      caught_q   <= caught_d;
      timeout_q  <= timeout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pend_dir_d = pend_dir_q;
    pend_v_d   = pend_v_q;
    cur_dir_d  = cur_dir_q;
    cur_v_d    = cur_v_q;
    req_d      = req_q;
    tile_x_d   = tile_x_q;
    tile_y_d   = tile_y_q;
    oob_d      = oob_q;
    cnt_d      = cnt_q;
    pac_x_d    = pac_x_q;
    pac_y_d    = pac_y_q;
    caught_d   = caught_q;
    timeout_d  = 1'b0;

    // A strobe always lands in the pending register. This also overrides the
    // pending clear on a committing ack below, so a strobe arriving with the
    // ack survives.
    if (state_q != S_CAUGHT && i_dir_valid) begin
      pend_dir_d = i_dir;
      pend_v_d   = 1'b1;
    end

    if (state_q != S_CAUGHT && collision) begin
      state_d  = S_CAUGHT;
      caught_d = 1'b1;
      req_d    = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_step && pend_v_q) begin
            state_d  = S_REQ_NEXT;
            tile_x_d = pend_tgt.x;
            tile_y_d = pend_tgt.y;
            oob_d    = pend_tgt.oob;
            req_d    = !pend_tgt.oob;
            cnt_d    = 4'd0;
          end else if (i_step && cur_v_q) begin
            state_d  = S_REQ_CUR;
            tile_x_d = cur_tgt.x;
            tile_y_d = cur_tgt.y;
            oob_d    = cur_tgt.oob;
            req_d    = !cur_tgt.oob;
            cnt_d    = 4'd0;
          end
        end

        S_REQ_NEXT: begin
          // An out-of-maze target resolves as a wall in its entry cycle.
          if (oob_q || (i_tile_ack && i_tile_wall)) begin
            if (cur_v_q) begin
              state_d  = S_REQ_CUR;
              tile_x_d = cur_tgt.x;
              tile_y_d = cur_tgt.y;
              oob_d    = cur_tgt.oob;
              req_d    = !cur_tgt.oob;
              cnt_d    = 4'd0;
            end else begin
              state_d = S_IDLE;
              req_d   = 1'b0;
            end
          end else if (i_tile_ack) begin
            state_d   = S_IDLE;
            req_d     = 1'b0;
            pac_x_d   = tile_x_q;
            pac_y_d   = tile_y_q;
            cur_dir_d = pend_dir_q;
            cur_v_d   = 1'b1;
            if (!i_dir_valid) begin
              pend_v_d = 1'b0;
            end
          end else if (cnt_q == TO_LAST) begin
            state_d   = S_IDLE;
            req_d     = 1'b0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        S_REQ_CUR: begin
          if (oob_q || (i_tile_ack && i_tile_wall)) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            cur_v_d = 1'b0;
          end else if (i_tile_ack) begin
            state_d = S_IDLE;
            req_d   = 1'b0;
            pac_x_d = tile_x_q;
            pac_y_d = tile_y_q;
          end else if (cnt_q == TO_LAST) begin
            state_d   = S_IDLE;
            req_d     = 1'b0;
            timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end

        S_CAUGHT: begin
          req_d = 1'b0;
        end

        default: begin
          state_d = S_IDLE;
          req_d   = 1'b0;
        end
      endcase
    end
  end

  assign o_tile_req = req_q;
  assign o_tile_x   = tile_x_q;
  assign o_tile_y   = tile_y_q;
  assign o_pac_x    = pac_x_q;
  assign o_pac_y    = pac_y_q;
  assign o_busy     = (state_q != S_IDLE);
  assign o_caught   = caught_q;
  assign o_timeout  = timeout_q;

endmodule
